// File: rtl/s2p_if.sv
// Bundle of the s2p serial-side inputs and parallel-side handshake outputs.
// The slave modport is the receiver view; master is the driver/consumer view.
interface s2p_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             d_in;
  logic             shift;
  logic             clear;
  logic             ack;
  logic [WIDTH-1:0] d_out;
  logic             valid;
  logic             busy;
  logic             overrun;
  logic             par_err;

  modport master (
    output d_in, shift, clear, ack,
    input  d_out, valid, busy, overrun, par_err
  );

  modport slave (
    input  d_in, shift, clear, ack,
    output d_out, valid, busy, overrun, par_err
  );
endinterface

// File: rtl/s2p.sv
// LSB-first serial-to-parallel receiver with valid/ack handshake and sticky overrun.
// Define PARITY_CHECK_EN to receive a trailing parity bit per frame and report par_err.
module s2p #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic  clk,
  input logic  rst_n,
  s2p_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  localparam int unsigned Frame = WIDTH + 1;
`else
  localparam int unsigned Frame = WIDTH;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(Frame - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             complete;

  assign shifted = {bus.d_in, sr_q[WIDTH-1:1]};

`ifdef PARITY_CHECK_EN
  // The final strobe carries the parity bit, so the data is already complete in sr.
  assign word = sr_q;
`else
  assign word = shifted;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    d_out_d   = d_out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;

    if (bus.clear) begin
      state_d   = StIdle;
      cnt_d     = '0;
      sr_d      = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (bus.ack) begin
        valid_d = 1'b0;
      end
      if (bus.shift) begin
        unique case (state_q)
          StIdle: begin
            sr_d    = shifted;
            cnt_d   = CntW'(1);
            state_d = StRecv;
          end
          StRecv: begin
            if (cnt_q == LastCnt) begin
              complete = 1'b1;
              d_out_d  = word;
              valid_d  = 1'b1;
              sr_d     = '0;
              cnt_d    = '0;
              state_d  = StIdle;
              if (valid_q && !bus.ack) begin
                overrun_d = 1'b1;
              end
            end else begin
              sr_d  = shifted;
              cnt_d = cnt_q + CntW'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sr_q      <= '0;
      d_out_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      d_out_q   <= d_out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (bus.clear) begin
      par_err_d = 1'b0;
    end else if (complete) begin
      par_err_d = ((^sr_q) ^ bus.d_in) != (PARITY_ODD != 0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign bus.par_err = par_err_q;
`else
  // Bit 0 is shifted out with each sample and never read back without parity.
  logic unused_sr0;
  logic unused_parity_odd;
  logic unused_complete;
  assign unused_sr0        = sr_q[0];
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign unused_complete   = complete;
  assign bus.par_err       = 1'b0;
`endif

  assign bus.d_out   = d_out_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = (state_q == StRecv);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_s2p.sv
// Directed bench for s2p: queue-based reference model checked every cycle, plus literal checks.
module tb_s2p;
  localparam int W = 8;
  localparam bit POdd = 1'b0;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   cmp_en = 1'b0;

  s2p_if #(.WIDTH(W)) bus ();

  s2p #(.WIDTH(W), .PARITY_ODD(POdd)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: collect received bits in a queue, emit a word once a frame is in.
  bit         m_q[$];
  logic [W-1:0] exp_dout;
  logic       exp_valid, exp_overrun, exp_par;

  function automatic logic [W-1:0] pack_word(input bit q[$]);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = q[i];
    return r;
  endfunction

  function automatic logic frame_par_err(input bit q[$]);
`ifdef PARITY_CHECK_EN
    return ((^pack_word(q)) ^ q[W]) != POdd;
`else
    return (q.size() < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_dout    <= '0;
      exp_valid   <= 1'b0;
      exp_overrun <= 1'b0;
      exp_par     <= 1'b0;
    end else if (bus.clear) begin
      m_q.delete();
      exp_valid   <= 1'b0;
      exp_overrun <= 1'b0;
      exp_par     <= 1'b0;
    end else begin
      if (bus.ack) exp_valid <= 1'b0;
      if (bus.shift) begin
        m_q.push_back(bus.d_in);
        if (m_q.size() == FRAME) begin
          exp_dout  <= pack_word(m_q);
          exp_valid <= 1'b1;
          exp_par   <= frame_par_err(m_q);
          if (exp_valid && !bus.ack) exp_overrun <= 1'b1;
          m_q.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc d_out", 32'(bus.d_out), 32'(exp_dout));
      check("cyc valid", 32'(bus.valid), 32'(exp_valid));
      check("cyc busy", 32'(bus.busy), 32'(m_q.size() != 0));
      check("cyc overrun", 32'(bus.overrun), 32'(exp_overrun));
      check("cyc par_err", 32'(bus.par_err), 32'(exp_par));
    end
  end

  task automatic tick(input logic d, input logic sh, input logic clr, input logic ak);
    bus.d_in  = d;
    bus.shift = sh;
    bus.clear = clr;
    bus.ack   = ak;
    @(posedge clk);
    #1;
    cyc++;
    bus.shift = 1'b0;
    bus.clear = 1'b0;
    bus.ack   = 1'b0;
  endtask

  function automatic logic even_pbit(input logic [W-1:0] w);
    return (^w) ^ POdd;
  endfunction

  task automatic send(input logic [W-1:0] w, input int gap, input logic ack_first,
                      input logic ack_last, input logic pbit);
    logic [W:0] f;
    f = {pbit, w};
    for (int i = 0; i < FRAME; i++) begin
      tick(f[i], 1'b1, 1'b0, (ack_first && i == 0) || (ack_last && i == FRAME - 1));
      if (i != FRAME - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick(1'b0, 1'b0, 1'b0, 1'b0);
          check("gap busy", 32'(bus.busy), 32'd1);
        end
      end
    end
  endtask

  int t1, t2;

  initial begin
    rst_n     = 1'b0;
    bus.d_in  = 1'b0;
    bus.shift = 1'b0;
    bus.clear = 1'b0;
    bus.ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst d_out", 32'(bus.d_out), 32'h0);
    check("rst valid", 32'(bus.valid), 32'h0);
    check("rst busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic word 0xA5
    send(8'hA5, 0, 1'b0, 1'b0, even_pbit(8'hA5));
    check("basic d_out", 32'(bus.d_out), 32'hA5);
    check("model A5", 32'(exp_dout), 32'hA5);
    check("basic valid", 32'(bus.valid), 32'd1);
    check("basic busy", 32'(bus.busy), 32'd0);
    check("basic overrun", 32'(bus.overrun), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("ack valid", 32'(bus.valid), 32'd0);
    check("ack d_out", 32'(bus.d_out), 32'hA5);

    // Gapped strobes
    send(8'h3C, 2, 1'b0, 1'b0, even_pbit(8'h3C));
    check("gap d_out", 32'(bus.d_out), 32'h3C);
    check("gap valid", 32'(bus.valid), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun, then cleared by clear
    send(8'h11, 0, 1'b0, 1'b0, even_pbit(8'h11));
    send(8'h22, 0, 1'b0, 1'b0, even_pbit(8'h22));
    check("ovr d_out", 32'(bus.d_out), 32'h22);
    check("ovr valid", 32'(bus.valid), 32'd1);
    check("ovr overrun", 32'(bus.overrun), 32'd1);
    check("model ovr", 32'(exp_overrun), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr overrun", 32'(bus.overrun), 32'd0);
    check("clr valid", 32'(bus.valid), 32'd0);
    check("clr d_out kept", 32'(bus.d_out), 32'h22);

    // Ack on the completion edge prevents overrun
    send(8'h11, 0, 1'b0, 1'b0, even_pbit(8'h11));
    send(8'h22, 0, 1'b0, 1'b1, even_pbit(8'h22));
    check("ackovr d_out", 32'(bus.d_out), 32'h22);
    check("ackovr valid", 32'(bus.valid), 32'd1);
    check("ackovr overrun", 32'(bus.overrun), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames, ack riding on the next frame's first strobe
    send(8'h5A, 0, 1'b0, 1'b0, even_pbit(8'h5A));
    t1 = cyc;
    check("b2b first", 32'(bus.d_out), 32'h5A);
    send(8'hC3, 0, 1'b1, 1'b0, even_pbit(8'hC3));
    t2 = cyc;
    check("b2b second", 32'(bus.d_out), 32'hC3);
    check("b2b valid", 32'(bus.valid), 32'd1);
    check("b2b overrun", 32'(bus.overrun), 32'd0);
    check("b2b spacing", 32'(t2 - t1), 32'(FRAME));
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort mid-frame with clear+shift, then a clean frame
    repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("abort busy before", 32'(bus.busy), 32'd1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort d_out kept", 32'(bus.d_out), 32'hC3);
    send(8'h0F, 0, 1'b0, 1'b0, even_pbit(8'h0F));
    check("abort d_out", 32'(bus.d_out), 32'h0F);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
    send(8'h07, 0, 1'b0, 1'b0, 1'b1);
    check("par good", 32'(bus.par_err), 32'd0);
    check("par good d_out", 32'(bus.d_out), 32'h07);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h07, 0, 1'b0, 1'b0, 1'b0);
    check("par bad", 32'(bus.par_err), 32'd1);
    check("model par bad", 32'(exp_par), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("par clr", 32'(bus.par_err), 32'd0);
`else
    t1 = cyc;
    send(8'h07, 0, 1'b0, 1'b0, 1'b0);
    check("nopar d_out", 32'(bus.d_out), 32'h07);
    check("nopar par_err", 32'(bus.par_err), 32'd0);
    check("nopar len", 32'(cyc - t1), 32'd8);
`endif

    // Asynchronous reset mid-frame
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst d_out", 32'(bus.d_out), 32'h0);
    check("arst valid", 32'(bus.valid), 32'h0);
    check("arst busy", 32'(bus.busy), 32'h0);
    check("arst overrun", 32'(bus.overrun), 32'h0);
    check("arst par_err", 32'(bus.par_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 0, 1'b0, 1'b0, even_pbit(8'hA5));
    check("post rst d_out", 32'(bus.d_out), 32'hA5);

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
